// File: rtl/reg_file_8x.sv
// 8-entry register file: one-hot write port, two registered read ports with
// write-to-read bypass, sticky multi-hot error flag and an 8-cycle scrub.
module reg_file_8x #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       we_oh,
  input  logic [WIDTH-1:0] wd,
  input  logic [2:0]       ra0,
  input  logic [2:0]       ra1,
  input  logic             clr,
  output logic [WIDTH-1:0] rd0,
  output logic [WIDTH-1:0] rd1,
  output logic             busy,
  output logic             err
);

  typedef enum logic {
    IDLE  = 1'b0,
    SCRUB = 1'b1
  } state_t;

  state_t           state, state_next;
  logic [2:0]       ptr, ptr_next;
  logic [WIDTH-1:0] mem [8];

  logic multi_hot;
  logic single_hot;
  logic idle_wr;
  logic scrub_start;
  logic wr_en;

  // Clearing the lowest set bit leaves something only when two or more bits are set.
  assign multi_hot   = |(we_oh & (we_oh - 8'd1));
  assign single_hot  = (we_oh != 8'd0) && !multi_hot;
  assign idle_wr     = (state == IDLE) && !clr;
  assign scrub_start = (state == IDLE) && clr;
  assign wr_en       = idle_wr && single_hot;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path leaves a latch.
    state_next = state;
    ptr_next   = ptr;
    case (state)
      IDLE: begin
        if (clr) begin
          state_next = SCRUB;
          ptr_next   = 3'd0;
        end
      end
      SCRUB: begin
        ptr_next = ptr + 3'd1;
        if (ptr == 3'd7) state_next = IDLE;
      end
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      ptr   <= 3'd0;
      busy  <= 1'b0;
      err   <= 1'b0;
    end else begin
      state <= state_next;
      ptr   <= ptr_next;
      busy  <= (state_next == SCRUB);
      if (scrub_start)            err <= 1'b0;
      else if (idle_wr && multi_hot) err <= 1'b1;
    end
  end

  // NOTE: the storage array is reset explicitly because reset must zero every entry,
  // which rules out mapping it onto a RAM macro without reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) mem[i] <= '0;
    end else begin
      for (int i = 0; i < 8; i++) begin
        if (wr_en && we_oh[i])                        mem[i] <= wd;
        else if ((state == SCRUB) && (ptr == 3'(i)))  mem[i] <= '0;
      end
    end
  end

  // Bypass only covers accepted writes; scrub zeroing is seen one cycle later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd0 <= '0;
      rd1 <= '0;
    end else begin
      rd0 <= (wr_en && we_oh[ra0]) ? wd : mem[ra0];
      rd1 <= (wr_en && we_oh[ra1]) ? wd : mem[ra1];
    end
  end

endmodule
